dpram_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4096x60 true-dual-port RAM between NUM_REQ independent requesters.
- Grants up to two requests per cycle: first winner on RAM port A, second winner on RAM port B.
- Registers the RAM-side command signals and routes read data back to the issuing requester with a valid strobe.
- Sits between compute/DMA clients and the dpram instance; it is the only driver of the dpram ports.

---
 rtl/dpram_rr_arbiter_pkg.sv | 42 ++++
 rtl/dpram_rr_arbiter_if.sv | 26 ++
 rtl/dpram_rr_arbiter_rr_pick2.sv | 51 +++++
 rtl/dpram_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dpram_rr_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_rr_arbiter_pkg.sv
// Shared types and helpers for the dual-port RAM round-robin arbiter.
package dpram_arb_pkg;

    localparam int unsigned AWIDTH_DEF = 12;
    localparam int unsigned DWIDTH_DEF = 60;
    localparam int unsigned MAX_REQ    = 8;
    localparam int unsigned IDX_W      = 3;

    typedef logic [IDX_W-1:0] idx_t;

    // Pipeline tag: valid marks a read whose data must be routed back.
    typedef struct packed {
        logic valid;
        idx_t idx;
    } tag_t;

    typedef struct packed {
        logic found;
        idx_t idx;
    } pick_t;

    // First set bit of mask at or after ptr, searching cyclically over num entries.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] mask, input idx_t ptr,
                                      input int unsigned num);
        pick_t       r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = (32'(ptr) + k) % num;
            if ((k < num) && !r.found && mask[j[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[IDX_W-1:0];
            end
        end
        return r;
    endfunction

    function automatic idx_t idx_inc(input idx_t i, input int unsigned num);
        return idx_t'((32'(i) + 32'd1) % num);
    endfunction

endpackage

// File: rtl/dpram_rr_arbiter_if.sv
// Client-side request/grant/read-return bundle of the arbiter.
interface dpram_rr_arbiter_if
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned AWIDTH  = AWIDTH_DEF,
    parameter int unsigned DWIDTH  = DWIDTH_DEF
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*AWIDTH-1:0] req_addr;
    logic [NUM_REQ*DWIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [NUM_REQ*DWIDTH-1:0] rd_data;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rd_valid, rd_data
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/dpram_rr_arbiter_rr_pick2.sv
// Combinational dual-winner round-robin picker with same-address conflict masking.
module rr_pick2
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned AWIDTH  = AWIDTH_DEF
)(
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
    input  idx_t                      ptr,
    output pick_t                     win_a,
    output pick_t                     win_b
);
    logic [MAX_REQ-1:0] req_pad;
    logic [MAX_REQ-1:0] we_pad;
    logic [MAX_REQ-1:0] mask_b;
    logic [AWIDTH-1:0]  addr_arr [MAX_REQ];
    pick_t              cand_a;
    pick_t              cand_b;
    logic               conflict;

    // Unused slots above NUM_REQ read as idle so 3-bit indices stay in range.
    for (genvar g = 0; g < MAX_REQ; g++) begin : g_pad
        if (g < NUM_REQ) begin : g_used
            assign req_pad[g]  = req[g];
            assign we_pad[g]   = req_we[g];
            assign addr_arr[g] = req_addr[g*AWIDTH +: AWIDTH];
        end else begin : g_idle
            assign req_pad[g]  = 1'b0;
            assign we_pad[g]   = 1'b0;
            assign addr_arr[g] = '0;
        end
    end

    // Pick W0 from ptr, W1 from W0+1, then deny W1 on a write-involved address clash.
    always_comb begin
        cand_a = rr_pick(req_pad, ptr, NUM_REQ);
        mask_b = req_pad;
        mask_b[cand_a.idx] = 1'b0;
        cand_b = rr_pick(mask_b, idx_inc(cand_a.idx, NUM_REQ), NUM_REQ);
        conflict = cand_a.found && cand_b.found
                   && (addr_arr[cand_a.idx] == addr_arr[cand_b.idx])
                   && (we_pad[cand_a.idx] || we_pad[cand_b.idx]);
        win_a = cand_a;
        win_b = cand_b;
        if (conflict) begin
            win_b.found = 1'b0;
        end
    end
endmodule

// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter sharing one true-dual-port RAM among NUM_REQ clients.
module dpram_rr_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned AWIDTH  = AWIDTH_DEF,
    parameter int unsigned DWIDTH  = DWIDTH_DEF,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
)(
    input  logic               clk,
    input  logic               resetn,
    dpram_rr_arbiter_if.slave  cli,
    output logic [AWIDTH-1:0]  address_a,
    output logic [AWIDTH-1:0]  address_b,
    output logic               wren_a,
    output logic               wren_b,
    output logic [DWIDTH-1:0]  data_a,
    output logic [DWIDTH-1:0]  data_b,
    input  logic [DWIDTH-1:0]  out_a,
    input  logic [DWIDTH-1:0]  out_b
);
    if (IDW != $clog2(NUM_REQ)) begin : g_bad_idw
        $error("IDW must equal clog2(NUM_REQ)");
    end

    idx_t               rr_ptr;
    idx_t               ptr_nxt;
    pick_t              win_a;
    pick_t              win_b;
    logic [MAX_REQ-1:0] gnt_pad;
    logic [MAX_REQ-1:0] we_pad;
    logic [AWIDTH-1:0]  addr_arr  [MAX_REQ];
    logic [DWIDTH-1:0]  wdata_arr [MAX_REQ];
    tag_t               tag_a;
    tag_t               tag_b;
    tag_t               ret_a;
    tag_t               ret_b;

    for (genvar g = 0; g < MAX_REQ; g++) begin : g_pad
        if (g < NUM_REQ) begin : g_used
            assign we_pad[g]    = cli.req_we[g];
            assign addr_arr[g]  = cli.req_addr[g*AWIDTH +: AWIDTH];
            assign wdata_arr[g] = cli.req_wdata[g*DWIDTH +: DWIDTH];
        end else begin : g_idle
            assign we_pad[g]    = 1'b0;
            assign addr_arr[g]  = '0;
            assign wdata_arr[g] = '0;
        end
    end

    rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .AWIDTH  (AWIDTH)
    ) u_pick (
        .req      (cli.req),
        .req_we   (cli.req_we),
        .req_addr (cli.req_addr),
        .ptr      (rr_ptr),
        .win_a    (win_a),
        .win_b    (win_b)
    );

    // Grant decode, forced low while reset is asserted.
    always_comb begin
        gnt_pad = '0;
        if (resetn) begin
            if (win_a.found) gnt_pad[win_a.idx] = 1'b1;
            if (win_b.found) gnt_pad[win_b.idx] = 1'b1;
        end
    end

    assign cli.gnt = gnt_pad[NUM_REQ-1:0];

    // Next pointer follows the last granted requester.
    always_comb begin
        ptr_nxt = rr_ptr;
        if (win_b.found) begin
            ptr_nxt = idx_inc(win_b.idx, NUM_REQ);
        end else if (win_a.found) begin
            ptr_nxt = idx_inc(win_a.idx, NUM_REQ);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= ptr_nxt;
        end
    end

    // Command stage: winners drive the RAM ports; idle ports hold address/data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            address_a <= '0;
            address_b <= '0;
            data_a    <= '0;
            data_b    <= '0;
            wren_a    <= 1'b0;
            wren_b    <= 1'b0;
            tag_a     <= '0;
            tag_b     <= '0;
        end else begin
            wren_a <= 1'b0;
            wren_b <= 1'b0;
            tag_a  <= '0;
            tag_b  <= '0;
            if (win_a.found) begin
                address_a <= addr_arr[win_a.idx];
                data_a    <= wdata_arr[win_a.idx];
                wren_a    <= we_pad[win_a.idx];
                tag_a     <= tag_t'{valid: !we_pad[win_a.idx], idx: win_a.idx};
            end
            if (win_b.found) begin
                address_b <= addr_arr[win_b.idx];
                data_b    <= wdata_arr[win_b.idx];
                wren_b    <= we_pad[win_b.idx];
                tag_b     <= tag_t'{valid: !we_pad[win_b.idx], idx: win_b.idx};
            end
        end
    end

    // Return-stage tags, aligned with the RAM's registered read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ret_a <= '0;
            ret_b <= '0;
        end else begin
            ret_a <= tag_a;
            ret_b <= tag_b;
        end
    end

    // RAM data is only present in the strobe cycle, so rd_data bypasses out_x
    // while rd_valid is high and a per-requester register holds it afterwards.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ret
        localparam idx_t GI = idx_t'(g);
        logic              hit_a;
        logic              hit_b;
        logic [DWIDTH-1:0] hold_q;
        logic [DWIDTH-1:0] data_cur;

        assign hit_a    = ret_a.valid && (ret_a.idx == GI);
        assign hit_b    = ret_b.valid && (ret_b.idx == GI);
        assign data_cur = hit_a ? out_a : (hit_b ? out_b : hold_q);

        assign cli.rd_valid[g]                  = hit_a || hit_b;
        assign cli.rd_data[g*DWIDTH +: DWIDTH] = data_cur;

        // Hold the most recently returned word until the next strobe.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                hold_q <= '0;
            end else begin
                hold_q <= data_cur;
            end
        end
    end
endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Directed self-checking bench for dpram_rr_arbiter with a behavioural TDP RAM.
module tb_dpram_rr_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 60;

    localparam logic [DW-1:0] D1 = 60'h0ABCDEF123456789;
    localparam logic [DW-1:0] D2 = 60'h0DEADBEEF0CAFE1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [AW-1:0] address_a, address_b;
    logic          wren_a, wren_b;
    logic [DW-1:0] data_a, data_b;
    logic [DW-1:0] out_a = '0;
    logic [DW-1:0] out_b = '0;
    logic [DW-1:0] mem [4096];

    int checks = 0;
    int errors = 0;

    dpram_rr_arbiter_if #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW)) bus ();

    dpram_rr_arbiter #(
        .NUM_REQ (N),
        .AWIDTH  (AW),
        .DWIDTH  (DW),
        .IDW     (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cli       (bus),
        .address_a (address_a),
        .address_b (address_b),
        .wren_a    (wren_a),
        .wren_b    (wren_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_a     (out_a),
        .out_b     (out_b)
    );

    always #5 clk = ~clk;

    // True-dual-port RAM: 1-cycle registered read, output holds on a write.
    always @(posedge clk) begin
        if (wren_a) mem[address_a] = data_a;
        else        out_a <= mem[address_a];
        if (wren_b) mem[address_b] = data_b;
        else        out_b <= mem[address_b];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]              = 1'b1;
        bus.req_we[i]           = we;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle(input int i);
        bus.req[i]    = 1'b0;
        bus.req_we[i] = 1'b0;
    endtask

    function automatic logic [DW-1:0] rdd(input int i);
        return bus.rd_data[i*DW +: DW];
    endfunction

    initial begin
        logic [3:0] exp_g;
        logic [3:0] exp_v;

        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = {48'h123456789ABC, 12'(i)};

        // Reset with all clients requesting
        @(negedge clk);
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 12'h000, '0);
        #1;
        chk("rst_gnt", 64'(bus.gnt), 64'h0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
        chk("rst_wren_a", 64'(wren_a), 64'h0);
        chk("rst_addr_a", 64'(address_a), 64'h0);
        chk("rst_rd_data0", 64'(rdd(0)), 64'h0);

        @(negedge clk);
        for (int i = 0; i < 4; i++) idle(i);
        resetn = 1'b1;

        // Write D1 to 0x010 via client 0, then client 2 reads it back
        @(negedge clk);
        drive(0, 1'b1, 12'h010, D1);
        #1 chk("wr_gnt", 64'(bus.gnt), 64'h1);

        @(negedge clk);
        idle(0);
        drive(2, 1'b0, 12'h010, '0);
        #1;
        chk("rd_gnt", 64'(bus.gnt), 64'h4);
        chk("wr_addr_a", 64'(address_a), 64'h010);
        chk("wr_wren_a", 64'(wren_a), 64'h1);
        chk("wr_data_a", 64'(data_a), 64'(D1));
        chk("wr_wren_b", 64'(wren_b), 64'h0);

        @(negedge clk);
        idle(2);
        #1;
        chk("rd_cmd_addr_a", 64'(address_a), 64'h010);
        chk("rd_cmd_wren_a", 64'(wren_a), 64'h0);
        chk("rd_early_valid", 64'(bus.rd_valid), 64'h0);

        @(negedge clk);
        #1;
        chk("rd_valid", 64'(bus.rd_valid), 64'h4);
        chk("rd_data2", 64'(rdd(2)), 64'(D1));

        @(negedge clk);
        #1;
        chk("rd_valid_drop", 64'(bus.rd_valid), 64'h0);
        chk("rd_data2_hold", 64'(rdd(2)), 64'(D1));

        // Pointer wrap: ptr=3, clients 3 and 0 read
        @(negedge clk);
        drive(3, 1'b0, 12'h020, '0);
        drive(0, 1'b0, 12'h030, '0);
        #1 chk("wrap_gnt", 64'(bus.gnt), 64'h9);

        @(negedge clk);
        idle(3);
        idle(0);
        #1;
        chk("wrap_addr_a", 64'(address_a), 64'h020);
        chk("wrap_addr_b", 64'(address_b), 64'h030);
        chk("wrap_wren_b", 64'(wren_b), 64'h0);

        @(negedge clk);
        #1;
        chk("wrap_valid", 64'(bus.rd_valid), 64'h9);
        chk("wrap_data3", 64'(rdd(3)), 64'h123456789ABC020);
        chk("wrap_data0", 64'(rdd(0)), 64'h123456789ABC030);

        // Two reads of the same address are granted together (ptr=1)
        @(negedge clk);
        drive(1, 1'b0, 12'h7FF, '0);
        drive(3, 1'b0, 12'h7FF, '0);
        #1 chk("dual_gnt", 64'(bus.gnt), 64'hA);

        @(negedge clk);
        idle(1);
        idle(3);
        #1;
        chk("dual_addr_a", 64'(address_a), 64'h7FF);
        chk("dual_addr_b", 64'(address_b), 64'h7FF);

        @(negedge clk);
        #1;
        chk("dual_valid", 64'(bus.rd_valid), 64'hA);
        chk("dual_data1", 64'(rdd(1)), 64'h123456789ABC7FF);
        chk("dual_data3", 64'(rdd(3)), 64'h123456789ABC7FF);

        // Write/read conflict on 0x055 (ptr=0)
        @(negedge clk);
        drive(0, 1'b1, 12'h055, D2);
        drive(1, 1'b0, 12'h055, '0);
        #1 chk("conf_gnt0", 64'(bus.gnt), 64'h1);

        @(negedge clk);
        idle(0);
        #1;
        chk("conf_gnt1", 64'(bus.gnt), 64'h2);
        chk("conf_addr_a", 64'(address_a), 64'h055);
        chk("conf_wren_a", 64'(wren_a), 64'h1);
        chk("conf_data_a", 64'(data_a), 64'(D2));
        chk("conf_wren_b", 64'(wren_b), 64'h0);

        @(negedge clk);
        idle(1);
        #1;
        chk("conf_gnt_idle", 64'(bus.gnt), 64'h0);
        chk("conf_rd_wren_a", 64'(wren_a), 64'h0);

        @(negedge clk);
        #1;
        chk("conf_valid", 64'(bus.rd_valid), 64'h2);
        chk("conf_data1", 64'(rdd(1)), 64'(D2));

        // Reset one cycle after a read grant drops the in-flight read (ptr=2)
        @(negedge clk);
        drive(2, 1'b0, 12'h010, '0);
        #1 chk("mid_gnt", 64'(bus.gnt), 64'h4);

        @(negedge clk);
        idle(2);
        drive(1, 1'b0, 12'h100, '0);
        resetn = 1'b0;
        #1;
        chk("mid_rst_gnt", 64'(bus.gnt), 64'h0);
        chk("mid_rst_addr_a", 64'(address_a), 64'h0);
        chk("mid_rst_wren_a", 64'(wren_a), 64'h0);
        chk("mid_rst_valid", 64'(bus.rd_valid), 64'h0);
        chk("mid_rst_data2", 64'(rdd(2)), 64'h0);

        @(negedge clk);
        idle(1);
        resetn = 1'b1;
        #1 chk("mid_no_valid_t2", 64'(bus.rd_valid), 64'h0);

        @(negedge clk);
        #1 chk("mid_no_valid_t3", 64'(bus.rd_valid), 64'h0);

        // All four clients read continuously after reset (ptr=0)
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (c < 4) drive(i, 1'b0, 12'(12'h100 + i), '0);
                else       idle(i);
            end
            #1;
            exp_g = (c < 4) ? ((c % 2 == 1) ? 4'b1100 : 4'b0011) : 4'b0000;
            exp_v = (c >= 2) ? ((c % 2 == 1) ? 4'b1100 : 4'b0011) : 4'b0000;
            chk($sformatf("all_gnt_c%0d", c), 64'(bus.gnt), 64'(exp_g));
            chk($sformatf("all_valid_c%0d", c), 64'(bus.rd_valid), 64'(exp_v));
            for (int i = 0; i < 4; i++) begin
                if (exp_v[i]) begin
                    chk($sformatf("all_data%0d_c%0d", i, c), 64'(rdd(i)),
                        64'({48'h123456789ABC, 12'(12'h100 + i)}));
                end
            end
            if (c == 1) chk("all_addr_b_c1", 64'(address_b), 64'h101);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
